options_serializer: RTL and testbench
=====================================

OPTIONS_SERIALIZER -- requirements
Module: options_serializer

Interface
REQ-001 Parameter WS_MAX, default 14, meaning upper clamp applied to window-scale shift count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 optsIn_mss_valid / optsIn_mss  input  1 / 16  MSS option present / value.
REQ-005 optsIn_ws_valid / optsIn_ws  input  1 / 8  window-scale option present / shift count.
REQ-006 optsIn_sackPerm  input  1  SACK-permitted option present.
REQ-007 optsIn_ts_valid / optsIn_tsval / optsIn_tsecr  input  1 / 32 / 32  timestamp option present / TSval / TSecr.
REQ-008 optsIn_sync  input  1  producer offers option set; optsIn_notify  output  1  block ready to accept.
REQ-009 wordsOut_sig  output  32  current options word, network byte order, MSB first.
REQ-010 wordsOut_last  output  1  current word is final word of set; wordsOut_len  output  3  total words in set (0..5).
REQ-011 wordsOut_notify  output  1  word valid; wordsOut_sync  input  1  consumer ready.

Function
REQ-012 Transfer on either port SHALL occur only in a cycle where its sync and notify are both high.
REQ-013 optsIn_notify SHALL be high exactly while state is IDLE; inputs are captured into internal registers on the accepting edge and ignored otherwise.
REQ-014 States: IDLE, MSS, TSHDR, TSVAL, TSECR, SACK, WS; word order MSS, then TS group or SACK, then WS; absent options skipped.
REQ-015 MSS word = 0x0204_0000 | mss.
REQ-016 TSHDR word = 0x0402_080A when sackPerm, else 0x0101_080A; followed by TSVAL word = tsval, TSECR word = tsecr.
REQ-017 SACK state (sackPerm without TS) word = 0x0101_0402.
REQ-018 WS word = 0x0103_0300 | min(ws, WS_MAX).
REQ-019 wordsOut_len = mss_valid + 3*ts_valid + (sackPerm & !ts_valid) + ws_valid, computed at capture, held constant until return to IDLE.
REQ-020 First word SHALL be valid the cycle after acceptance (latency 1); each subsequent word valid the cycle after the previous transfer.
REQ-021 While wordsOut_notify high and wordsOut_sync low, wordsOut_sig, wordsOut_last, wordsOut_len SHALL hold stable (stall).
REQ-022 Transfer of the word with wordsOut_last high SHALL return state to IDLE; optsIn_notify high the next cycle; no back-to-back accept in the same cycle.
REQ-023 Empty set (no option present): accepted, wordsOut_len = 0, no word emitted, state returns to IDLE next cycle.
REQ-024 wordsOut_notify SHALL be low in IDLE; wordsOut_sig drives 0 when notify low.

Reset
REQ-025 rst high on an edge SHALL force IDLE, optsIn_notify = 1 after release, wordsOut_notify = 0, wordsOut_last = 0, wordsOut_len = 0, wordsOut_sig = 0, captured registers = 0.
REQ-026 rst mid-emission SHALL abandon the set with no further word of it emitted.

Configuration
REQ-027 Macro OPTIONS_SERIALIZER_TS_EN: defined -> timestamp handling per REQ-016; undefined -> ts inputs ignored, TSHDR/TSVAL/TSECR states absent, sackPerm always emitted per REQ-017, len excludes TS.

Verification
REQ-028 mss=1460 only, sync ready -> one word 0x020405B4, last=1, len=1, notify back high 2 cycles after accept.
REQ-029 mss=1460, sackPerm, ts(0x11223344,0x0), ws=7 -> 0x020405B4, 0x0402080A, 0x11223344, 0x00000000, 0x01030307; len=5; last only on fifth.
REQ-030 ws=20 only -> 0x0103030E (clamped to 14); sackPerm only -> 0x01010402.
REQ-031 Full set with wordsOut_sync low 3 cycles on TSVAL -> word held stable 3 cycles, order and count unchanged.
REQ-032 Empty set -> no wordsOut_notify, optsIn_notify high again one cycle later; rst asserted during TSHDR -> IDLE, no TSVAL emitted.
REQ-033 Without OPTIONS_SERIALIZER_TS_EN, set of REQ-029 -> 0x020405B4, 0x01010402, 0x01030307, len=3.

Source files
------------

// File: rtl/options_serializer.sv
// Serializes a captured TCP option set into 32-bit network-order words: MSS, TS group or SACK, then WS.
// Optional timestamp support is enabled by defining OPTIONS_SERIALIZER_TS_EN.
module options_serializer #(
  parameter int unsigned WS_MAX = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        optsIn_mss_valid,
  input  logic [15:0] optsIn_mss,
  input  logic        optsIn_ws_valid,
  input  logic [7:0]  optsIn_ws,
  input  logic        optsIn_sackPerm,
  input  logic        optsIn_ts_valid,
  input  logic [31:0] optsIn_tsval,
  input  logic [31:0] optsIn_tsecr,
  input  logic        optsIn_sync,
  output logic        optsIn_notify,
  output logic [31:0] wordsOut_sig,
  output logic        wordsOut_last,
  output logic [2:0]  wordsOut_len,
  output logic        wordsOut_notify,
  input  logic        wordsOut_sync
);

`ifdef OPTIONS_SERIALIZER_TS_EN
  typedef enum logic [2:0] {IDLE, MSS, TSHDR, TSVAL, TSECR, SACK, WS} state_e;
`else
  typedef enum logic [2:0] {IDLE, MSS, SACK, WS} state_e;
`endif

  localparam logic [7:0] WS_MAX_B = 8'(WS_MAX);

  state_e      state_q, state_d;
  logic        mss_v_q, mss_v_d;
  logic [15:0] mss_q, mss_d;
  logic        ws_v_q, ws_v_d;
  logic [7:0]  ws_q, ws_d;
  logic        sack_q, sack_d;
  logic [2:0]  len_q, len_d;
`ifdef OPTIONS_SERIALIZER_TS_EN
  logic        ts_v_q, ts_v_d;
  logic [31:0] tsval_q, tsval_d;
  logic [31:0] tsecr_q, tsecr_d;
  logic        ts_in;
  assign ts_in = optsIn_ts_valid;
`else
  logic        unused_ts;
  logic        ts_in;
  assign unused_ts = ^{optsIn_ts_valid, optsIn_tsval, optsIn_tsecr};
  assign ts_in     = 1'b0;
`endif

  // Successor word state given the captured option flags; IDLE means the set is exhausted.
  function automatic state_e next_state(input state_e st, input logic mss_v,
`ifdef OPTIONS_SERIALIZER_TS_EN
                                        input logic ts_v,
`endif
                                        input logic sack, input logic ws_v);
    state_e after_sack, after_mss, n;
    after_sack = ws_v ? WS : IDLE;
`ifdef OPTIONS_SERIALIZER_TS_EN
    after_mss  = ts_v ? TSHDR : (sack ? SACK : after_sack);
`else
    after_mss  = sack ? SACK : after_sack;
`endif
    case (st)
      IDLE:  n = mss_v ? MSS : after_mss;
      MSS:   n = after_mss;
`ifdef OPTIONS_SERIALIZER_TS_EN
      TSHDR: n = TSVAL;
      TSVAL: n = TSECR;
      TSECR: n = after_sack;
`endif
      SACK:  n = after_sack;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  state_e     nxt_cap, nxt_run;
  logic [7:0] ws_clamp;
  logic [2:0] len_cap;

  always_comb begin
    ws_clamp = (optsIn_ws > WS_MAX_B) ? WS_MAX_B : optsIn_ws;
    len_cap  = {2'b0, optsIn_mss_valid} + (ts_in ? 3'd3 : 3'd0)
             + {2'b0, optsIn_sackPerm & ~ts_in} + {2'b0, optsIn_ws_valid};
`ifdef OPTIONS_SERIALIZER_TS_EN
    nxt_cap = next_state(IDLE, optsIn_mss_valid, optsIn_ts_valid, optsIn_sackPerm, optsIn_ws_valid);
    nxt_run = next_state(state_q, mss_v_q, ts_v_q, sack_q, ws_v_q);
`else
    nxt_cap = next_state(IDLE, optsIn_mss_valid, optsIn_sackPerm, optsIn_ws_valid);
    nxt_run = next_state(state_q, mss_v_q, sack_q, ws_v_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    mss_v_d = mss_v_q;
    mss_d   = mss_q;
    ws_v_d  = ws_v_q;
    ws_d    = ws_q;
    sack_d  = sack_q;
    len_d   = len_q;
`ifdef OPTIONS_SERIALIZER_TS_EN
    ts_v_d  = ts_v_q;
    tsval_d = tsval_q;
    tsecr_d = tsecr_q;
`endif
    optsIn_notify   = (state_q == IDLE);
    wordsOut_notify = (state_q != IDLE);
    wordsOut_last   = wordsOut_notify && (nxt_run == IDLE);
    wordsOut_len    = len_q;
    wordsOut_sig    = '0;

    case (state_q)
      MSS:   wordsOut_sig = {16'h0204, mss_q};
`ifdef OPTIONS_SERIALIZER_TS_EN
      TSHDR: wordsOut_sig = sack_q ? 32'h0402_080A : 32'h0101_080A;
      TSVAL: wordsOut_sig = tsval_q;
      TSECR: wordsOut_sig = tsecr_q;
`endif
      SACK:  wordsOut_sig = 32'h0101_0402;
      WS:    wordsOut_sig = {24'h010303, ws_q};
      default: wordsOut_sig = '0;
    endcase

    if (state_q == IDLE) begin
      if (optsIn_sync) begin
        mss_v_d = optsIn_mss_valid;
        mss_d   = optsIn_mss;
        ws_v_d  = optsIn_ws_valid;
        ws_d    = ws_clamp;
        sack_d  = optsIn_sackPerm;
`ifdef OPTIONS_SERIALIZER_TS_EN
        ts_v_d  = optsIn_ts_valid;
        tsval_d = optsIn_tsval;
        tsecr_d = optsIn_tsecr;
`endif
        // An empty set yields nxt_cap == IDLE, so nothing is emitted.
        len_d   = (nxt_cap == IDLE) ? 3'd0 : len_cap;
        state_d = nxt_cap;
      end
    end else if (wordsOut_sync) begin
      state_d = nxt_run;
      if (nxt_run == IDLE) len_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mss_v_q <= 1'b0;
      mss_q   <= '0;
      ws_v_q  <= 1'b0;
      ws_q    <= '0;
      sack_q  <= 1'b0;
      len_q   <= '0;
`ifdef OPTIONS_SERIALIZER_TS_EN
      ts_v_q  <= 1'b0;
      tsval_q <= '0;
      tsecr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mss_v_q <= mss_v_d;
      mss_q   <= mss_d;
      ws_v_q  <= ws_v_d;
      ws_q    <= ws_d;
      sack_q  <= sack_d;
      len_q   <= len_d;
`ifdef OPTIONS_SERIALIZER_TS_EN
      ts_v_q  <= ts_v_d;
      tsval_q <= tsval_d;
      tsecr_q <= tsecr_d;
`endif
    end
  end

endmodule

// File: tb/tb_options_serializer.sv
// Directed bench for options_serializer: reset, single options, full set, stall, empty set, reset mid-set.
module tb_options_serializer;
  logic        clk = 1'b0;
  logic        rst;
  logic        optsIn_mss_valid, optsIn_ws_valid, optsIn_sackPerm, optsIn_ts_valid, optsIn_sync;
  logic [15:0] optsIn_mss;
  logic [7:0]  optsIn_ws;
  logic [31:0] optsIn_tsval, optsIn_tsecr;
  logic        optsIn_notify, wordsOut_last, wordsOut_notify, wordsOut_sync;
  logic [31:0] wordsOut_sig;
  logic [2:0]  wordsOut_len;

  always #5 clk = ~clk;

  options_serializer #(.WS_MAX(14)) dut (
    .clk(clk), .rst(rst),
    .optsIn_mss_valid(optsIn_mss_valid), .optsIn_mss(optsIn_mss),
    .optsIn_ws_valid(optsIn_ws_valid), .optsIn_ws(optsIn_ws),
    .optsIn_sackPerm(optsIn_sackPerm),
    .optsIn_ts_valid(optsIn_ts_valid), .optsIn_tsval(optsIn_tsval), .optsIn_tsecr(optsIn_tsecr),
    .optsIn_sync(optsIn_sync), .optsIn_notify(optsIn_notify),
    .wordsOut_sig(wordsOut_sig), .wordsOut_last(wordsOut_last), .wordsOut_len(wordsOut_len),
    .wordsOut_notify(wordsOut_notify), .wordsOut_sync(wordsOut_sync)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] w_sig [8];
  logic        w_last[8];
  logic [2:0]  w_len [8];
  int          w_n;
  logic [31:0] h_sig [8];
  logic        h_last[8];
  int          h_n;
  bit          w_to;

  // Expected full-set sequence for mss=1460, sackPerm, ts(0x11223344,0), ws=7.
`ifdef OPTIONS_SERIALIZER_TS_EN
  localparam int FULL_N = 5;
  localparam int STALL_IDX = 2;
  logic [31:0] exp_full[8] = '{32'h020405B4, 32'h0402080A, 32'h11223344, 32'h00000000,
                               32'h01030307, 32'h0, 32'h0, 32'h0};
`else
  localparam int FULL_N = 3;
  localparam int STALL_IDX = 1;
  logic [31:0] exp_full[8] = '{32'h020405B4, 32'h01010402, 32'h01030307,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif

  task automatic clear_inputs();
    optsIn_mss_valid = 0; optsIn_mss = '0; optsIn_ws_valid = 0; optsIn_ws = '0;
    optsIn_sackPerm = 0; optsIn_ts_valid = 0; optsIn_tsval = '0; optsIn_tsecr = '0;
    optsIn_sync = 0; wordsOut_sync = 1;
  endtask

  // Offers one set, waits for the accepting edge, then scrambles inputs to prove they are captured.
  task automatic send_set(input logic mv, input logic [15:0] m, input logic wv, input logic [7:0] w,
                          input logic sp, input logic tv, input logic [31:0] tsv, input logic [31:0] tse);
    @(negedge clk);
    optsIn_mss_valid = mv; optsIn_mss = m; optsIn_ws_valid = wv; optsIn_ws = w;
    optsIn_sackPerm = sp; optsIn_ts_valid = tv; optsIn_tsval = tsv; optsIn_tsecr = tse;
    optsIn_sync = 1;
    for (int i = 0; i < 20 && !optsIn_notify; i++) @(negedge clk);
    @(posedge clk);
    #1;
    optsIn_sync = 0;
    optsIn_mss_valid = 1; optsIn_mss = 16'hDEAD; optsIn_ws_valid = 1; optsIn_ws = 8'h05;
    optsIn_sackPerm = ~sp; optsIn_ts_valid = 1; optsIn_tsval = 32'hCAFEBABE; optsIn_tsecr = 32'h12345678;
  endtask

  // Records emitted words; holds wordsOut_sync low for stall_n cycles on word stall_idx.
  task automatic collect(input int stall_idx, input int stall_n);
    int st;
    st = 0; w_n = 0; h_n = 0; w_to = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wordsOut_notify && w_n < 8) begin
        if (w_n == stall_idx && st < stall_n) begin
          wordsOut_sync = 0;
          h_sig[h_n] = wordsOut_sig; h_last[h_n] = wordsOut_last; h_n++; st++;
        end else begin
          wordsOut_sync = 1;
          w_sig[w_n] = wordsOut_sig; w_last[w_n] = wordsOut_last; w_len[w_n] = wordsOut_len; w_n++;
          if (wordsOut_last) begin
            @(posedge clk); #1;
            w_to = 0;
            break;
          end
        end
      end
    end
    wordsOut_sync = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    optsIn_mss_valid = 1; optsIn_mss = 16'h1234; optsIn_sync = 1;
    repeat (2) @(posedge clk);
    #1; clear_inputs(); rst = 0;
    @(negedge clk);
    n_checks++; if (optsIn_notify !== 1'b1) begin n_fail++; $display("FAIL reset_optsIn_notify got=%b exp=1", optsIn_notify); end
    n_checks++; if (wordsOut_notify !== 1'b0) begin n_fail++; $display("FAIL reset_wordsOut_notify got=%b exp=0", wordsOut_notify); end
    n_checks++; if (wordsOut_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", wordsOut_last); end
    n_checks++; if (wordsOut_len !== 3'd0) begin n_fail++; $display("FAIL reset_len got=%0d exp=0", wordsOut_len); end
    n_checks++; if (wordsOut_sig !== 32'h0) begin n_fail++; $display("FAIL reset_sig got=%h exp=0", wordsOut_sig); end
  endtask

  task automatic test_mss_only();
    clear_inputs();
    send_set(1, 16'd1460, 0, 8'd0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++; if (wordsOut_notify !== 1'b1) begin n_fail++; $display("FAIL mss_latency_notify got=%b exp=1", wordsOut_notify); end
    n_checks++; if (wordsOut_sig !== 32'h020405B4) begin n_fail++; $display("FAIL mss_word got=%h exp=020405b4", wordsOut_sig); end
    n_checks++; if (wordsOut_last !== 1'b1) begin n_fail++; $display("FAIL mss_last got=%b exp=1", wordsOut_last); end
    n_checks++; if (wordsOut_len !== 3'd1) begin n_fail++; $display("FAIL mss_len got=%0d exp=1", wordsOut_len); end
    n_checks++; if (optsIn_notify !== 1'b0) begin n_fail++; $display("FAIL mss_busy_notify got=%b exp=0", optsIn_notify); end
    @(negedge clk);
    n_checks++; if (optsIn_notify !== 1'b1) begin n_fail++; $display("FAIL mss_return_idle got=%b exp=1", optsIn_notify); end
    n_checks++; if (wordsOut_notify !== 1'b0 || wordsOut_sig !== 32'h0) begin
      n_fail++; $display("FAIL mss_idle_out got notify=%b sig=%h exp notify=0 sig=0", wordsOut_notify, wordsOut_sig); end
    n_checks++; if (wordsOut_len !== 3'd0) begin n_fail++; $display("FAIL mss_idle_len got=%0d exp=0", wordsOut_len); end
  endtask

  task automatic test_single_opts();
    logic [7:0]  ws_in [4] = '{8'd20, 8'd14, 8'd13, 8'd255};
    logic [31:0] ws_exp[4] = '{32'h0103030E, 32'h0103030E, 32'h0103030D, 32'h0103030E};
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      send_set(0, 16'h0, 1, ws_in[i], 0, 0, 32'h0, 32'h0);
      collect(-1, 0);
      n_checks++; if (w_to || w_n !== 1 || w_sig[0] !== ws_exp[i] || w_last[0] !== 1'b1 || w_len[0] !== 3'd1) begin
        n_fail++; $display("FAIL ws_clamp[%0d] got to=%0b n=%0d sig=%h last=%b len=%0d exp n=1 sig=%h last=1 len=1",
                           i, w_to, w_n, w_sig[0], w_last[0], w_len[0], ws_exp[i]); end
    end
    send_set(0, 16'h0, 0, 8'd0, 1, 0, 32'h0, 32'h0);
    collect(-1, 0);
    n_checks++; if (w_to || w_n !== 1 || w_sig[0] !== 32'h01010402 || w_len[0] !== 3'd1) begin
      n_fail++; $display("FAIL sack_only got to=%0b n=%0d sig=%h len=%0d exp n=1 sig=01010402 len=1",
                         w_to, w_n, w_sig[0], w_len[0]); end
  endtask

  task automatic check_full(input string tag);
    n_checks++; if (w_to || w_n !== FULL_N) begin
      n_fail++; $display("FAIL %s_count got to=%0b n=%0d exp n=%0d", tag, w_to, w_n, FULL_N); end
    for (int i = 0; i < FULL_N; i++) begin
      n_checks++; if (w_sig[i] !== exp_full[i] || w_last[i] !== (i == FULL_N - 1) || w_len[i] !== 3'(FULL_N)) begin
        n_fail++; $display("FAIL %s_word[%0d] got sig=%h last=%b len=%0d exp sig=%h last=%b len=%0d",
                           tag, i, w_sig[i], w_last[i], w_len[i], exp_full[i], (i == FULL_N - 1), FULL_N); end
    end
  endtask

  task automatic test_full_set();
    clear_inputs();
    send_set(1, 16'd1460, 1, 8'd7, 1, 1, 32'h11223344, 32'h0);
    collect(-1, 0);
    check_full("full");
  endtask

  task automatic test_stall();
    clear_inputs();
    send_set(1, 16'd1460, 1, 8'd7, 1, 1, 32'h11223344, 32'h0);
    collect(STALL_IDX, 3);
    check_full("stall");
    n_checks++; if (h_n !== 3) begin n_fail++; $display("FAIL stall_cycles got=%0d exp=3", h_n); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (h_sig[i] !== exp_full[STALL_IDX] || h_last[i] !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d] got sig=%h last=%b exp sig=%h last=0",
                           i, h_sig[i], h_last[i], exp_full[STALL_IDX]); end
    end
  endtask

  task automatic test_empty();
    clear_inputs();
    send_set(0, 16'h0, 0, 8'd0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (wordsOut_notify !== 1'b0 || optsIn_notify !== 1'b1 || wordsOut_len !== 3'd0) begin
        n_fail++; $display("FAIL empty[%0d] got wnotify=%b inotify=%b len=%0d exp 0/1/0",
                           i, wordsOut_notify, optsIn_notify, wordsOut_len); end
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    send_set(1, 16'd1460, 1, 8'd7, 1, 1, 32'h11223344, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (wordsOut_notify !== 1'b1 || wordsOut_sig !== exp_full[1]) begin
      n_fail++; $display("FAIL rstmid_pre got notify=%b sig=%h exp notify=1 sig=%h", wordsOut_notify, wordsOut_sig, exp_full[1]); end
    rst = 1; wordsOut_sync = 0;
    @(posedge clk); #1;
    rst = 0; wordsOut_sync = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (wordsOut_notify !== 1'b0 || optsIn_notify !== 1'b1 || wordsOut_len !== 3'd0) begin
        n_fail++; $display("FAIL rstmid_abandon[%0d] got wnotify=%b inotify=%b len=%0d exp 0/1/0",
                           i, wordsOut_notify, optsIn_notify, wordsOut_len); end
    end
  endtask

  initial begin
    test_reset();
    test_mss_only();
    test_single_opts();
    test_full_set();
    test_stall();
    test_empty();
    test_reset_mid();
    test_full_set();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
